// File: rtl/minterm_enumerator_if.sv
// rtl/minterm_enumerator_if.sv - minterm stream port: valid/ready handshake carrying one index
interface minterm_enumerator_if #(
    parameter int N_VARS = 11
);
    logic              m_valid;
    logic              m_ready;
    logic [N_VARS-1:0] m_index;

    modport master (output m_valid, output m_index, input m_ready);
    modport slave  (input m_valid, input m_index, output m_ready);
endinterface

// File: rtl/minterm_enumerator.sv
// rtl/minterm_enumerator.sv - sweeps all input indices of a combinational function
// and streams every index where it evaluates to 1.
module minterm_enumerator #(
    parameter int N_VARS = 11
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic [N_VARS-1:0]    o_func_in,
    input  logic                 i_func_out,
    minterm_enumerator_if.master m_if,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [N_VARS:0]      o_minterm_count
);
    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_HOLD, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [N_VARS-1:0] r_func_in;
    logic [N_VARS-1:0] r_m_index;
    logic [N_VARS:0]   r_count;
    logic              w_last;

    // The all-ones index ends the sweep; the index never wraps back to zero.
    assign w_last = &r_func_in;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_EVAL;
            S_EVAL: begin
                if (i_func_out)  w_next = S_HOLD;
                else if (w_last) w_next = S_DONE;
            end
            S_HOLD: if (m_if.m_ready) w_next = w_last ? S_DONE : S_EVAL;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // func_in stays put in HOLD so the function output remains consistent with m_index.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_func_in <= '0;
            r_m_index <= '0;
            r_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_func_in <= '0;
                        r_count   <= '0;
                    end
                end
                S_EVAL: begin
                    if (i_func_out) begin
                        r_m_index <= r_func_in;
                        r_count   <= r_count + (N_VARS+1)'(1);
                    end else if (!w_last) begin
                        r_func_in <= r_func_in + N_VARS'(1);
                    end
                end
                S_HOLD: begin
                    if (m_if.m_ready && !w_last) r_func_in <= r_func_in + N_VARS'(1);
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_busy       = (r_state == S_EVAL) || (r_state == S_HOLD);
        o_done       = (r_state == S_DONE);
        m_if.m_valid = (r_state == S_HOLD);
    end

    assign m_if.m_index    = r_m_index;
    assign o_func_in       = r_func_in;
    assign o_minterm_count = r_count;
endmodule
